// File: rtl/uart_tp_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tp_receiver
//  Description : 8N1 UART receiver and "T=<n>\n" / "P=<n>\n" line parser.
//                Parsed 16-bit values are held pending and committed to the
//                output registers only on frame_start, so a value never
//                changes while a frame is being drawn. Single clock domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tp_receiver #(
  parameter int unsigned CLK_HZ  = 74000000,
  parameter int unsigned BAUD    = 115200,
  parameter logic [15:0] T_RESET = 16'd0,
  parameter logic [15:0] P_RESET = 16'd0
) (
  input  logic        clk_pix,
  input  logic        rst_pix_n,
  input  logic        uart_rx,
  input  logic        frame_start,
  output logic [15:0] t_value,
  output logic [15:0] p_value,
  output logic        t_update,
  output logic        p_update,
  output logic        parse_err
);

  // Bit period in clocks; very low ratios are clamped so the half-bit
  // start-bit check still has room to count.
  localparam int unsigned CPB_RAW      = CLK_HZ / BAUD;
  localparam int unsigned CLKS_PER_BIT = (CPB_RAW < 4) ? 4 : CPB_RAW;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] P_IDLE    = 2'd0;
  localparam logic [1:0] P_EQ      = 2'd1;
  localparam logic [1:0] P_DIGIT   = 2'd2;
  localparam logic [1:0] P_DISCARD = 2'd3;

  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_T  = 8'h54;
  localparam logic [7:0] C_P  = 8'h50;
  localparam logic [7:0] C_EQ = 8'h3D;

  // ---------------------------------------------------------------- receiver
  logic             rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic [1:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             w_rx_byte_vld, w_rx_frame_err;

  // Two-flop synchroniser plus a delayed copy for start-edge detection.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_sync1_q <= uart_rx;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
    end
  end

  // Receiver state register and its bit-timing datapath.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Receiver next state: mid-bit sampling driven by the cycle counter.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == C_HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          // A line already back high at mid start bit was only a glitch.
          rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == C_BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      default: begin
        if (rx_cnt_q == C_BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
        end
      end
    endcase
  end

  // Receiver outputs: byte strobe or framing error at the stop-bit sample.
  always_comb begin
    w_rx_byte_vld  = 1'b0;
    w_rx_frame_err = 1'b0;
    if (rx_state_q == RX_STOP && rx_cnt_q == C_BIT_LAST) begin
      w_rx_byte_vld  = rx_sync2_q;
      w_rx_frame_err = !rx_sync2_q;
    end
  end

  // ------------------------------------------------------------------ parser
  logic [1:0]  ps_state_q, ps_state_d;
  logic [16:0] acc_q, acc_d;
  logic        has_dig_q, has_dig_d;
  logic        tgt_p_q, tgt_p_d;
  logic        w_is_digit, w_is_lf, w_is_cr, w_ovf, w_byte;
  logic [20:0] w_acc_next;
  logic        w_err, w_commit_t, w_commit_p;

  assign w_byte     = w_rx_byte_vld && (rx_shift_q != C_CR);
  assign w_is_digit = (rx_shift_q >= 8'h30) && (rx_shift_q <= 8'h39);
  assign w_is_lf    = (rx_shift_q == C_LF);
  assign w_is_cr    = (rx_shift_q == C_CR);
  assign w_acc_next = 21'(acc_q) * 21'd10 + 21'(rx_shift_q[3:0]);
  assign w_ovf      = (w_acc_next > 21'd65535);

  // Parser state register and accumulator.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      ps_state_q <= P_IDLE;
      acc_q      <= '0;
      has_dig_q  <= 1'b0;
      tgt_p_q    <= 1'b0;
    end else begin
      ps_state_q <= ps_state_d;
      acc_q      <= acc_d;
      has_dig_q  <= has_dig_d;
      tgt_p_q    <= tgt_p_d;
    end
  end

  // Parser next state; carriage returns are invisible to every state.
  always_comb begin
    ps_state_d = ps_state_q;
    acc_d      = acc_q;
    has_dig_d  = has_dig_q;
    tgt_p_d    = tgt_p_q;
    if (w_rx_frame_err) begin
      if (ps_state_q != P_IDLE) ps_state_d = P_DISCARD;
    end else if (w_byte) begin
      case (ps_state_q)
        P_IDLE: begin
          if (rx_shift_q == C_T || rx_shift_q == C_P) begin
            tgt_p_d    = (rx_shift_q == C_P);
            ps_state_d = P_EQ;
          end else if (!w_is_lf) begin
            ps_state_d = P_DISCARD;
          end
        end
        P_EQ: begin
          if (rx_shift_q == C_EQ) begin
            acc_d      = '0;
            has_dig_d  = 1'b0;
            ps_state_d = P_DIGIT;
          end else begin
            ps_state_d = P_DISCARD;
          end
        end
        P_DIGIT: begin
          if (w_is_digit) begin
            if (w_ovf) begin
              ps_state_d = P_DISCARD;
            end else begin
              acc_d     = w_acc_next[16:0];
              has_dig_d = 1'b1;
            end
          end else if (w_is_lf) begin
            ps_state_d = P_IDLE;
          end else begin
            ps_state_d = P_DISCARD;
          end
        end
        default: begin
          if (w_is_lf) ps_state_d = P_IDLE;
        end
      endcase
    end
  end

  // Parser outputs: reject strobe and per-target commit strobes.
  always_comb begin
    w_err      = w_rx_frame_err;
    w_commit_t = 1'b0;
    w_commit_p = 1'b0;
    if (w_rx_byte_vld && !w_is_cr) begin
      case (ps_state_q)
        P_IDLE:  w_err = !(rx_shift_q == C_T || rx_shift_q == C_P || w_is_lf);
        P_EQ:    w_err = (rx_shift_q != C_EQ);
        P_DIGIT: begin
          if (w_is_digit)   w_err = w_ovf;
          else if (w_is_lf) w_err = !has_dig_q;
          else              w_err = 1'b1;
          w_commit_t = w_is_lf && has_dig_q && !tgt_p_q;
          w_commit_p = w_is_lf && has_dig_q &&  tgt_p_q;
        end
        default: w_err = 1'b0;
      endcase
    end
  end

  // ------------------------------------------------------------ commit stage
  logic        pend_t_q, pend_p_q;
  logic [15:0] pend_t_val_q, pend_p_val_q;
  logic [15:0] t_value_q, p_value_q;
  logic        t_update_q, p_update_q, parse_err_q;

  // Pending values move to the outputs only on frame_start; a commit landing
  // on that same edge re-arms the flag and waits for the next frame.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      pend_t_q     <= 1'b0;
      pend_p_q     <= 1'b0;
      pend_t_val_q <= '0;
      pend_p_val_q <= '0;
      t_value_q    <= T_RESET;
      p_value_q    <= P_RESET;
      t_update_q   <= 1'b0;
      p_update_q   <= 1'b0;
      parse_err_q  <= 1'b0;
    end else begin
      parse_err_q <= w_err;
      t_update_q  <= frame_start && pend_t_q;
      p_update_q  <= frame_start && pend_p_q;
      if (frame_start && pend_t_q) t_value_q <= pend_t_val_q;
      if (frame_start && pend_p_q) p_value_q <= pend_p_val_q;
      if (w_commit_t) pend_t_val_q <= acc_q[15:0];
      if (w_commit_p) pend_p_val_q <= acc_q[15:0];
      pend_t_q <= w_commit_t || (pend_t_q && !frame_start);
      pend_p_q <= w_commit_p || (pend_p_q && !frame_start);
    end
  end

  assign t_value   = t_value_q;
  assign p_value   = p_value_q;
  assign t_update  = t_update_q;
  assign p_update  = p_update_q;
  assign parse_err = parse_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tp_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tp_receiver
//  Description : Scoreboard bench for uart_tp_receiver (10 clocks per bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tp_receiver;

  localparam int CPB = 10;

  logic        clk_pix = 1'b0;
  logic        rst_pix_n, uart_rx, frame_start;
  logic [15:0] t_value, p_value;
  logic        t_update, p_update, parse_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] q_t[$];
  logic [15:0] q_p[$];
  int          q_err[$];

  uart_tp_receiver #(
    .CLK_HZ (1000000),
    .BAUD   (100000),
    .T_RESET(16'd0),
    .P_RESET(16'd0)
  ) dut (
    .clk_pix    (clk_pix),
    .rst_pix_n  (rst_pix_n),
    .uart_rx    (uart_rx),
    .frame_start(frame_start),
    .t_value    (t_value),
    .p_value    (p_value),
    .t_update   (t_update),
    .p_update   (p_update),
    .parse_err  (parse_err)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the next expected scoreboard entry.
  always @(negedge clk_pix) begin
    if (rst_pix_n === 1'b1) begin
      if (t_update !== 1'b0) begin
        if (q_t.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL t_update_unexpected: got pulse (t_value=%0d), expected none", t_value);
        end else check("t_update_value", 32'(t_value), 32'(q_t.pop_front()));
      end
      if (p_update !== 1'b0) begin
        if (q_p.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL p_update_unexpected: got pulse (p_value=%0d), expected none", p_value);
        end else check("p_update_value", 32'(p_value), 32'(q_p.pop_front()));
      end
      if (parse_err !== 1'b0) begin
        if (q_err.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL parse_err_unexpected: got pulse, expected none");
        end else check("parse_err_pulse", 32'(parse_err), 32'(q_err.pop_front() + 1));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk_pix);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk_pix);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk_pix);
    uart_rx = 1'b1;
    if (!stop_ok) repeat (2 * CPB) @(negedge clk_pix);
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    repeat (5) @(negedge clk_pix);
  endtask

  task automatic drained(input string tag);
    check({tag, "_t_queue"},   32'(q_t.size()),   32'd0);
    check({tag, "_p_queue"},   32'(q_p.size()),   32'd0);
    check({tag, "_err_queue"}, 32'(q_err.size()), 32'd0);
  endtask

  task automatic pulse_frame(input string tag);
    frame_start = 1'b1;
    @(negedge clk_pix);
    frame_start = 1'b0;
    repeat (4) @(negedge clk_pix);
    drained(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    uart_rx     = 1'b1;
    frame_start = 1'b0;
    rst_pix_n   = 1'b0;
    repeat (3) @(negedge clk_pix);
    check("reset_t_value",   32'(t_value),   32'd0);
    check("reset_p_value",   32'(p_value),   32'd0);
    check("reset_t_update",  32'(t_update),  32'd0);
    check("reset_p_update",  32'(p_update),  32'd0);
    check("reset_parse_err", 32'(parse_err), 32'd0);
    rst_pix_n = 1'b1;
    repeat (5) @(negedge clk_pix);

    // Basic T line, held until frame_start.
    send_line("T=1234\n");
    check("t_held_before_frame", 32'(t_value), 32'd0);
    q_t.push_back(16'd1234);
    pulse_frame("frame1");
    check("t_after_frame1", 32'(t_value), 32'd1234);
    check("p_untouched",    32'(p_value), 32'd0);

    // Maximum value with CR, then overflow rejection.
    send_line("P=65535\r\n");
    q_p.push_back(16'd65535);
    pulse_frame("frame2");
    check("p_max", 32'(p_value), 32'd65535);
    q_err.push_back(0);
    send_line("P=65536\n");
    drained("overflow");
    pulse_frame("frame3");
    check("p_kept_after_ovf", 32'(p_value), 32'd65535);

    // Last write wins, single pulse.
    send_line("T=5\n");
    send_line("T=7\n");
    q_t.push_back(16'd7);
    pulse_frame("frame4");
    check("t_last_wins", 32'(t_value), 32'd7);

    // Framing error mid-line discards the rest of the line.
    send_line("T=12");
    q_err.push_back(0);
    send_byte(8'h34, 1'b0);
    send_line("3\n");
    drained("framing");
    pulse_frame("frame5");
    check("t_kept_after_ferr", 32'(t_value), 32'd7);
    send_line("T=9\n");
    q_t.push_back(16'd9);
    pulse_frame("frame6");
    check("t_after_recover", 32'(t_value), 32'd9);

    // Commit landing on the same edge as frame_start waits one frame.
    send_line("T=42");
    hit = 1'b0;
    fork
      send_byte(8'h0A, 1'b1);
      begin
        for (int k = 0; k < 20 * CPB && !hit; k++) begin
          @(negedge clk_pix);
          if (dut.w_rx_byte_vld === 1'b1) begin
            frame_start = 1'b1;
            hit = 1'b1;
            @(negedge clk_pix);
            frame_start = 1'b0;
          end
        end
      end
    join
    check("collide_aligned", 32'(hit), 32'd1);
    repeat (5) @(negedge clk_pix);
    check("t_not_yet_applied", 32'(t_value), 32'd9);
    q_t.push_back(16'd42);
    pulse_frame("frame7");
    check("t_applied_next", 32'(t_value), 32'd42);

    // Half-bit glitch must not produce a byte.
    uart_rx = 1'b0;
    repeat (CPB / 2) @(negedge clk_pix);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk_pix);
    drained("glitch");
    send_line("P=12\n");
    q_p.push_back(16'd12);
    pulse_frame("frame8");
    check("p_after_glitch", 32'(p_value), 32'd12);

    // Reset mid-byte with a pending P value: nothing stale survives.
    send_line("P=77\n");
    send_line("P=");
    fork
      send_byte(8'h34, 1'b1);
      begin
        repeat (35) @(negedge clk_pix);
        rst_pix_n = 1'b0;
        repeat (80) @(negedge clk_pix);
        rst_pix_n = 1'b1;
      end
    join
    repeat (5) @(negedge clk_pix);
    check("p_reset_value", 32'(p_value), 32'd0);
    check("t_reset_value", 32'(t_value), 32'd0);
    pulse_frame("frame9");
    check("p_no_stale", 32'(p_value), 32'd0);
    send_line("P=00003\n");
    q_p.push_back(16'd3);
    pulse_frame("frame10");
    check("p_leading_zeros", 32'(p_value), 32'd3);

    repeat (10) @(negedge clk_pix);
    drained("final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tp_receiver.md
Name: uart_tp_receiver

Overview:
Upstream source of the T/P values consumed by the HDMI text renderer. The block receives 8N1 UART ASCII command lines ("T=1234\n", "P=5678\n") and parses them into 16-bit unsigned values. It stages each parsed value as pending and commits it to the output registers only at a frame boundary, so the renderer never shows a value that changes mid-frame. It runs entirely in the pixel clock domain.

Parameters:
CLK_HZ, 74000000, pixel clock frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, minimum 4)
T_RESET, 16'd0, t_value after reset
P_RESET, 16'd0, p_value after reset

Ports:
clk_pix  input  1  pixel clock, single clock for the block
rst_pix_n  input  1  reset, asynchronous assert, active-low (release synchronised externally)
uart_rx  input  1  raw asynchronous UART line, idle high
frame_start  input  1  one-cycle pulse at start of a frame (first pixel after vblank)
t_value  output  16  committed T value
p_value  output  16  committed P value
t_update  output  1  one-cycle pulse when t_value changes
p_update  output  1  one-cycle pulse when p_value changes
parse_err  output  1  one-cycle pulse on a rejected line or framing error

Behaviour:
- Reset: t_value=T_RESET, p_value=P_RESET, all pulses 0, pending flags clear, RX FSM IDLE, parser IDLE, synchroniser flops = 1.
- uart_rx passes through a 2-FF synchroniser before any use.
- RX FSM (IDLE, START, DATA, STOP). IDLE -> START on a synced 1->0 edge. START waits CLKS_PER_BIT/2 cycles, then re-samples: low -> DATA; high -> IDLE (glitch, no error). DATA samples 8 bits LSB-first, one every CLKS_PER_BIT cycles. STOP samples after a further CLKS_PER_BIT cycles. High -> the byte is strobed to the parser for one cycle. Low -> framing error. In both cases STOP -> IDLE.
- Parser FSM (P_IDLE, P_EQ, P_DIGIT, P_DISCARD). '\r' (0x0D) is ignored in every state.
  - P_IDLE: 'T' or 'P' selects the target and goes to P_EQ. '\n' stays in P_IDLE with no error. Any other byte -> P_DISCARD.
  - P_EQ: '=' clears the 17-bit accumulator and digit count, then goes to P_DIGIT. Any other byte -> P_DISCARD.
  - P_DIGIT: each '0'..'9' sets acc = acc*10 + digit. If the result exceeds 65535 -> P_DISCARD. '\n' with at least 1 digit commits acc[15:0] to the target's pending register, sets its pending flag, and returns to P_IDLE. '\n' with 0 digits is an error. Any other byte is an error.
  - P_DISCARD: waits for '\n', then returns to P_IDLE.
- parse_err pulses once per rejected line, on the cycle the parser enters P_DISCARD or rejects a '\n'. A framing error pulses parse_err and forces the parser to P_DISCARD (or P_IDLE if it was already in P_IDLE awaiting a line start).
- Commit timing: on frame_start, each set pending flag copies its pending register to t_value/p_value on the next edge, raises the matching *_update for that one cycle, and clears the flag.
- Pending flags are judged at their pre-edge value. A line committed in the same cycle as frame_start waits for the next frame_start.
- Multiple commits to the same target before frame_start: the last one wins, and only one update pulse is produced.
- An update pulse fires even if the new value equals the old value.
- Leading zeros are allowed ("T=00042" = 42). Up to 5 significant digits are accepted when the value stays at or below 65535. Any digit count is allowed as long as the accumulator stays at or below 65535.
- Async reset mid-byte or mid-line: the partial line is abandoned and pending flags clear.

Test Plan:
- CLK_HZ=1000000, BAUD=100000 (10 clks/bit). Send "T=1234\n", then pulse frame_start -> t_value=1234 and t_update high exactly 1 cycle on the edge after frame_start; p_value=0 and no p_update.
- Send "P=65535\r\n" then "P=65536\n", with frame_start after each -> p_value=65535 after the first. The second line gives 1 parse_err pulse, p_value stays 65535, and no p_update.
- Send "T=5\n" then "T=7\n" with no frame_start between, then one frame_start -> t_value=7 and a single t_update pulse.
- Send a byte whose stop bit is 0 in the middle of "T=12", then "3\n" -> 1 parse_err, line discarded, t_value unchanged. A following "T=9\n" plus frame_start gives t_value=9.
- Line commit on the same cycle as frame_start -> no update that frame; the next frame_start applies it.
- 0.5-bit low glitch on uart_rx -> no byte, no parse_err. Assert rst_pix_n low mid-"P=4" -> outputs return to P_RESET with no stale commit after release.
